ps2_frame_rx: RTL
=================

Name: ps2_frame_rx

Overview:
- Parametrised PS/2 device-to-host frame receiver; successor to the keyboard scancode shift/parity block.
- Brings the raw keyboard clock and data lines into the system clock domain and finds the falling edges of the keyboard clock.
- Deframes start, data, parity and stop bits with an explicit FSM, with selectable parity and an inter-bit timeout.
- Queues received codes with a per-entry error flag in a small FWFT FIFO, read by the keyboard decoder logic.

Parameters:
- DATA_W, 8, data bits per frame (sent LSB first).
- PARITY_MODE, 1, 0 = no parity bit, 1 = odd (standard PS/2), 2 = even.
- TIMEOUT_CYC, 50000, Clk cycles allowed between keyboard-clock falling edges inside a frame.
- FIFO_DEPTH, 4, queue entries; must be a power of two, at least 2.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- KbClk  in  1  raw PS/2 clock line (asynchronous).
- KbData  in  1  raw PS/2 data line (asynchronous).
- Pop  in  1  consume the head FIFO entry.
- ClrOvf  in  1  clear the sticky Overflow flag.
- ScanCode  out  DATA_W  head entry data.
- FrameErr  out  1  head entry parity or stop-bit error.
- Valid  out  1  FIFO not empty.
- Overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- Timeout  out  1  one-cycle pulse when a partial frame is aborted.
- Busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: one clock, asynchronous, active-high. While asserted:
  - synchroniser and edge flops preset to 1 (idle line is high);
  - FSM in IDLE; bit counter, timeout counter and FIFO pointers cleared;
  - all outputs 0.
  - Reset mid-frame discards the partial frame; no entry is written.
- Sync: 2-FF synchroniser on each of KbClk and KbData, plus one history flop on the clock line.
  - fall = hist & ~sync_clk; data is sampled on the same cycle from the synchronised KbData.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA and clear the bit counter. On fall with data=1, stay in IDLE (glitch or misaligned start).
  - DATA: on each fall, shift the sampled bit in at the MSB (right shift) and increment the counter. After DATA_W bits, go to PARITY, or to STOP when PARITY_MODE=0.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, capture the stop bit, push the entry and go to IDLE.
- Error flag: err = (stop != 1) | parity_bad.
  - Odd mode: parity_bad = ~^{data, p}. Even mode: parity_bad = ^{data, p}. Mode 0: parity_bad = 0.
  - Frames with errors are still queued, flagged FrameErr=1.
- Timeout:
  - The counter clears on every fall and in IDLE, and increments otherwise.
  - If the FSM is not in IDLE and the counter reaches TIMEOUT_CYC-1: go to IDLE, pulse Timeout for 1 cycle, no push.
  - If fall and timeout occur in the same cycle, fall wins.
- Latency: the FIFO write happens on the Clk edge at which the stop-bit fall is seen. Valid and the head data appear on the next cycle.
- FIFO: FWFT, FIFO_DEPTH entries of {err, data}, with pointers one bit wider than the address for full/empty.
  - ScanCode and FrameErr always show the head entry; they hold their last value when empty.
  - Pop with Valid=0 is ignored.
  - Push while full: the new entry is dropped and Overflow is set, unless Pop is asserted in the same cycle. In that case both happen and Overflow is unchanged.
  - Push and Pop together while not full: count unchanged, order preserved.
  - Overflow clears only on ClrOvf or Reset. If a set and ClrOvf occur in the same cycle, set wins.
- Busy = (state != IDLE).

Decomposition:
- Package ps2_rx_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - the parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the entry-width function DATA_W+1.
- One sub-module, ps2_rx_fifo. It is parametrised by width and depth and provides push, pop, full, empty, head data and an overflow-attempt output.
- Synchroniser, edge detect, FSM and timeout stay in the top level.

Test Plan:
- Valid frame, odd mode: KbData bits start 0, data 0x1C LSB first, parity 0, stop 1, with clean KbClk falls → after the stop fall, Valid=1 the next cycle, ScanCode=0x1C, FrameErr=0; Pop → Valid=0.
- Parity error: same frame for 0x1C with parity 1 → entry queued with ScanCode=0x1C, FrameErr=1.
- Stop error: frame 0xF0 with correct parity and stop=0 → FrameErr=1. Glitch fall with data=1 while idle → Busy remains 0 and no entry.
- Timeout: start plus 5 data bits, then idle for TIMEOUT_CYC cycles → Timeout pulses exactly 1 cycle, Busy=0, Valid=0. A following full frame 0x32 → ScanCode=0x32, FrameErr=0.
- Overflow: FIFO_DEPTH+1 frames 0x01..0x05 with no Pop → Overflow=1; pops return 0x01..0x04. Repeat with Pop held on the 5th stop fall → no overflow, 0x05 retained. ClrOvf → Overflow=0.
- Reset mid-frame: assert Reset between keyboard-clock edges after 4 data bits → outputs are 0 immediately, without waiting for a Clk edge. After release, a complete frame 0x5A → single entry 0x5A, no residue from the partial frame.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_rx_pkg;

  // Deframing FSM states
  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Parity selection values for PARITY_MODE
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // FIFO entry is {err, data}
  function automatic int unsigned entry_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small first-word-fall-through FIFO with overflow-attempt reporting.
// The head output holds the last popped entry while the queue is empty.
module ps2_rx_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wr_ptr_q;
  logic [AddrW:0]   rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  // Status flags and the qualified push/pop strobes
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = ({~wr_ptr_q[AddrW], wr_ptr_q[AddrW-1:0]} == rd_ptr_q);
    do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs
    do_push = push & (~full | do_pop);
    ovf     = push & ~do_push;
    rdata   = empty ? last_q : mem_q[rd_ptr_q[AddrW-1:0]];
  end

  // Storage, pointers and held head value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
        wr_ptr_q <= wr_ptr_q + (AddrW + 1)'(1);
      end
      if (do_pop) begin
        last_q   <= mem_q[rd_ptr_q[AddrW-1:0]];
        rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: line synchroniser, falling-edge detect,
// deframing FSM with optional parity and inter-bit timeout, and an output FIFO.
module ps2_frame_rx
  import ps2_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              KbClk,
  input  logic              KbData,
  input  logic              Pop,
  input  logic              ClrOvf,
  output logic [DATA_W-1:0] ScanCode,
  output logic              FrameErr,
  output logic              Valid,
  output logic              Overflow,
  output logic              Timeout,
  output logic              Busy
);

  localparam int unsigned EntryW = entry_w(DATA_W);
  localparam int unsigned CntW   = $clog2(DATA_W + 1);
  localparam int unsigned TmoW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  logic              clk_meta_q, clk_sync_q, clk_hist_q;
  logic              data_meta_q, data_sync_q;
  logic              fall;

  rx_state_e         state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [TmoW-1:0]   tmo_q;
  logic              tmo_hit;
  logic              push;
  logic              parity_bad;
  logic [EntryW-1:0] entry;
  logic [EntryW-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ovf_attempt;
  logic              ovf_q;

  // Two-stage synchronisers plus clock-line history; idle line level is high
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_hist_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= KbClk;
      clk_sync_q  <= clk_meta_q;
      clk_hist_q  <= clk_sync_q;
      data_meta_q <= KbData;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall = clk_hist_q & ~clk_sync_q;

  // FSM and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
    end
  end

  // Next-state logic; a clock fall beats a timeout in the same cycle
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push      = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A fall with data high is a glitch or misaligned start
        if (fall && !data_sync_q) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {data_sync_q, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) begin
            state_d = (PARITY_MODE == PAR_NONE) ? StStop : StParity;
          end
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = data_sync_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if ((state_q != StIdle) && !fall && (tmo_q == TmoLast)) begin
      state_d = StIdle;
      tmo_hit = 1'b1;
    end
  end

  // Inter-bit timeout counter, restarted by every fall and held clear in idle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tmo_q <= '0;
    end else if (fall || (state_q == StIdle)) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end

  // Frame error: stop bit is the live sample at the stop-bit fall
  always_comb begin
    if (PARITY_MODE == PAR_ODD) begin
      parity_bad = ~^{shift_q, par_q};
    end else if (PARITY_MODE == PAR_EVEN) begin
      parity_bad = ^{shift_q, par_q};
    end else begin
      parity_bad = 1'b0;
    end
    entry = {(~data_sync_q | parity_bad), shift_q};
  end

  ps2_rx_fifo #(
    .Width(EntryW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk  (Clk),
    .rst  (Reset),
    .push (push),
    .pop  (Pop),
    .wdata(entry),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .ovf  (ovf_attempt)
  );

  // Sticky overflow; a new drop takes priority over a clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ovf_q <= 1'b0;
    end else if (ovf_attempt && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (ClrOvf) begin
      ovf_q <= 1'b0;
    end
  end

  // Output mapping
  always_comb begin
    ScanCode = head[DATA_W-1:0];
    FrameErr = head[DATA_W];
    Valid    = ~fifo_empty;
    Overflow = ovf_q;
    Timeout  = tmo_hit;
    Busy     = (state_q != StIdle);
  end

endmodule
